// File: rtl/vga_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_sched_pkg : shared state type and constants for the VGA prefetcher    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package vga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    FRAME_END = 2'd2,
    PAUSE     = 2'd3
  } sched_state_t;

  localparam int FRAME_WORDS_DEFAULT = 307200;
  localparam int c_VGA_IDX_W         = 19;

endpackage
`default_nettype wire

// File: rtl/vga_credit_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_credit_counter : in-flight read counter, retire-underflow flag, cap   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_credit_counter #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = 7
) (
  input  logic             clk,
  input  logic             portV_arst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             below_cap,
  output logic             retire_err
);

  logic [CNT_W-1:0] r_count;
  logic             r_err;

  // Simultaneous inc/dec cancel; a lone retire at zero is a protocol error.
  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (inc && !dec) begin
      r_count <= r_count + 1'b1;
    end else if (dec && !inc) begin
      if (r_count == '0) r_err   <= 1'b1;
      else               r_count <= r_count - 1'b1;
    end
  end

  assign count      = r_count;
  assign below_cap  = (r_count < CNT_W'(MAX_OUTSTANDING));
  assign retire_err = r_err;

endmodule
`default_nettype wire

// File: rtl/vga_prefetch_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_prefetch_scheduler : credit-based VGA read issue, frame-aligned swap  |
// | Optional VGA_PREFETCH_STATS_EN adds underrun/peak statistics outputs.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_prefetch_scheduler
  import vga_sched_pkg::*;
#(
  parameter int FRAME_WORDS     = FRAME_WORDS_DEFAULT,
  parameter int ADDR_W          = 25,
  parameter int MARGIN          = 20,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              portV_arst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] buf0_base,
  input  logic [ADDR_W-1:0] buf1_base,
  input  logic              swap_req,
  input  logic [7:0]        cmdb_usedw,
  input  logic [8:0]        out_usedw,
  input  logic              rsp_retire,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [ADDR_W-1:0] active_base,
  output logic              frame_start,
  output logic              swap_ack,
  output logic              retire_err
`ifdef VGA_PREFETCH_STATS_EN
  ,
  output logic [15:0]       underrun_count,
  output logic [7:0]        peak_outstanding
`endif
);

  localparam int                     c_CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_VGA_IDX_W-1:0] c_LAST_IDX = c_VGA_IDX_W'(FRAME_WORDS - 1);

  sched_state_t           r_state;
  sched_state_t           w_state_nxt;
  logic [c_VGA_IDX_W-1:0] r_index;
  logic                   r_cmd_valid;
  logic [ADDR_W-1:0]      r_cmd_addr;
  logic                   r_sel;
  logic                   r_swap_pending;
  logic                   r_swap_ack;

  logic [c_CNT_W-1:0]     w_outstanding;
  logic                   w_below_cap;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_take_swap;
  logic [9:0]             w_demand;
  logic [9:0]             w_allow;
  logic                   w_credit_ok;
  logic                   w_issue;
  logic [ADDR_W-1:0]      w_base;

  assign w_accept    = r_cmd_valid & cmd_ready;
  assign w_last      = (r_index == c_LAST_IDX);
  assign w_take_swap = w_accept & w_last & r_swap_pending;
  assign w_base      = r_sel ? buf1_base : buf0_base;

  // Data already buffered plus reads in flight must stay below the allowance.
  assign w_demand    = {1'b0, out_usedw} + 10'(w_outstanding);
  assign w_allow     = 10'(cmdb_usedw >> 1) + 10'(MARGIN);
  assign w_credit_ok = (w_demand < w_allow);
  assign w_issue     = (r_state == STREAM) & enable & ~r_cmd_valid
                     & w_credit_ok & w_below_cap;

  vga_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (c_CNT_W)
  ) u_credit (
    .clk        (clk),
    .portV_arst (portV_arst),
    .inc        (w_accept),
    .dec        (rsp_retire),
    .count      (w_outstanding),
    .below_cap  (w_below_cap),
    .retire_err (retire_err)
  );

  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (enable) w_state_nxt = STREAM;
      STREAM: begin
        if (w_accept && w_last)          w_state_nxt = FRAME_END;
        else if (!enable && !r_cmd_valid) w_state_nxt = PAUSE;
      end
      FRAME_END: w_state_nxt = enable ? STREAM : PAUSE;
      PAUSE:     if (w_outstanding == '0) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // The buffer flip happens on the last-word accept so the new base is
  // already visible during the FRAME_END cycle alongside swap_ack.
  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      r_index        <= '0;
      r_cmd_valid    <= 1'b0;
      r_cmd_addr     <= '0;
      r_sel          <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_ack     <= 1'b0;
    end else begin
      r_swap_ack <= w_take_swap;
      if (w_take_swap) begin
        r_sel          <= ~r_sel;
        r_swap_pending <= 1'b0;
      end else if (swap_req) begin
        r_swap_pending <= 1'b1;
      end

      if (r_state == IDLE) r_index <= '0;
      else if (w_accept)   r_index <= w_last ? '0 : r_index + 1'b1;

      if (w_issue) begin
        r_cmd_valid <= 1'b1;
        r_cmd_addr  <= w_base + ADDR_W'(r_index);
      end else if (w_accept) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_addr    = r_cmd_addr;
  assign active_base = w_base;
  assign swap_ack    = r_swap_ack;
  assign frame_start = w_accept & (r_index == '0);

`ifdef VGA_PREFETCH_STATS_EN
  logic [15:0] r_underrun;
  logic [7:0]  r_peak;

  always_ff @(posedge clk or posedge portV_arst) begin
    if (portV_arst) begin
      r_underrun <= '0;
      r_peak     <= '0;
    end else begin
      if ((r_state == STREAM) && (out_usedw == '0) && (r_underrun != 16'hFFFF))
        r_underrun <= r_underrun + 1'b1;
      if (8'(w_outstanding) > r_peak)
        r_peak <= 8'(w_outstanding);
    end
  end

  assign underrun_count   = r_underrun;
  assign peak_outstanding = r_peak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_prefetch_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_prefetch_scheduler : directed bench with a frame-level ref model   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vga_prefetch_scheduler;

  localparam int FW     = 8;
  localparam int AW     = 25;
  localparam int MARGIN = 20;
  localparam int MAXO   = 64;

  logic          clk = 1'b0;
  logic          portV_arst;
  logic          enable;
  logic [AW-1:0] buf0_base;
  logic [AW-1:0] buf1_base;
  logic          swap_req;
  logic [7:0]    cmdb_usedw;
  logic [8:0]    out_usedw;
  logic          rsp_retire;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] active_base;
  logic          frame_start;
  logic          swap_ack;
  logic          retire_err;
`ifdef VGA_PREFETCH_STATS_EN
  logic [15:0]   underrun_count;
  logic [7:0]    peak_outstanding;
`endif

  always #5 clk = ~clk;

  vga_prefetch_scheduler #(
    .FRAME_WORDS(FW), .ADDR_W(AW), .MARGIN(MARGIN), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .portV_arst(portV_arst), .enable(enable),
    .buf0_base(buf0_base), .buf1_base(buf1_base), .swap_req(swap_req),
    .cmdb_usedw(cmdb_usedw), .out_usedw(out_usedw), .rsp_retire(rsp_retire),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .active_base(active_base), .frame_start(frame_start), .swap_ack(swap_ack),
    .retire_err(retire_err)
`ifdef VGA_PREFETCH_STATS_EN
    , .underrun_count(underrun_count), .peak_outstanding(peak_outstanding)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position, buffer choice, credit and error state.
  int            m_out, m_idx;
  bit            m_sel, m_pend, m_err, m_ack;
  bit            p_valid, p_ready, p_ok;
  logic [AW-1:0] p_addr;
  int            n_acc, n_fs, n_ack;
  logic [AW-1:0] acc_q[$];

  always @(negedge clk) begin
    logic [AW-1:0] eb;
    bit            acc;
    bit            take;
    if (portV_arst) begin
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_addr", cmd_addr, 0);
      chk("rst_swap_ack", swap_ack, 0);
      chk("rst_retire_err", retire_err, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_active_base", active_base, buf0_base);
      m_out = 0; m_idx = 0; m_sel = 0; m_pend = 0; m_err = 0; m_ack = 0;
      p_valid = 0; p_ready = 0; p_ok = 0; p_addr = '0;
    end else begin
      eb  = m_sel ? buf1_base : buf0_base;
      acc = cmd_valid && cmd_ready;
      chk("active_base", active_base, eb);
      chk("swap_ack", swap_ack, m_ack);
      chk("retire_err", retire_err, m_err);
      chk("frame_start", frame_start, acc && (m_idx == 0));
      if (cmd_valid) chk("cmd_addr", cmd_addr, AW'(eb + AW'(m_idx)));
      if (p_valid && !p_ready) begin
        chk("hold_valid", cmd_valid, 1);
        chk("hold_addr", cmd_addr, p_addr);
      end
      if (p_valid && p_ready) chk("gap_after_accept", cmd_valid, 0);
      if (cmd_valid && !p_valid) chk("issue_rule", p_ok, 1);

      if (acc) begin
        n_acc++;
        acc_q.push_back(cmd_addr);
      end
      if (frame_start) n_fs++;
      if (swap_ack) n_ack++;

      p_valid = cmd_valid;
      p_ready = cmd_ready;
      p_addr  = cmd_addr;
      p_ok    = enable && (int'(out_usedw) + m_out < int'(cmdb_usedw) / 2 + MARGIN)
                && (m_out < MAXO);

      take = acc && (m_idx == FW - 1) && m_pend;
      if (acc) m_idx = (m_idx == FW - 1) ? 0 : m_idx + 1;
      else if (!enable && !cmd_valid) m_idx = 0;
      m_ack = take;
      if (take) m_sel = ~m_sel;
      m_pend = take ? 1'b0 : (m_pend | swap_req);
      if (acc && !rsp_retire) m_out++;
      else if (!acc && rsp_retire) begin
        if (m_out == 0) m_err = 1;
        else m_out--;
      end
    end
  end

  bit auto_ret = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    swap_req   = 1'b0;
    rsp_retire = auto_ret && cmd_valid && cmd_ready;
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int c = 0;
    while (n_acc < target && c < budget) begin
      tick();
      c++;
    end
    chk(name, n_acc >= target, 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int c = 0;
    while (!cmd_valid && c < budget) begin
      tick();
      c++;
    end
    chk(name, cmd_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, fs0;
    portV_arst = 1; enable = 0; buf0_base = 25'h1000; buf1_base = 25'h2000;
    swap_req = 0; cmdb_usedw = 0; out_usedw = 0; rsp_retire = 0; cmd_ready = 0;
    repeat (3) tick();
    portV_arst = 0;
    tick();
    chk("init_valid", cmd_valid, 0);
    chk("init_addr", cmd_addr, 0);
    chk("init_base", active_base, 25'h1000);

    // Credit-limited burst: 20 reads, then silence.
    enable = 1; cmd_ready = 1;
    wait_acc(20, 100, "burst_reached_20");
    repeat (10) tick();
    chk("burst_count", n_acc, 20);
    chk("burst_first", acc_q[0], 25'h1000);
    chk("burst_last", acc_q[19], 25'h1003);
    chk("burst_frame_starts", n_fs, 3);
    chk("burst_idle_valid", cmd_valid, 0);

    // Backpressure with enable dropped while the command waits.
    cmd_ready = 0;
    rsp_retire = 1; tick();
    wait_valid(10, "reissue_after_retire");
    enable = 0;
    repeat (10) tick();
    chk("stall_valid", cmd_valid, 1);
    chk("stall_addr", cmd_addr, 25'h1004);
    cmd_ready = 1;
    tick();
    repeat (2) tick();
    chk("stall_completed", n_acc, 21);
    for (int i = 0; i < 20; i++) begin
      rsp_retire = 1;
      tick();
    end
    repeat (5) tick();
    chk("drain_no_err", retire_err, 0);
    chk("drain_no_valid", cmd_valid, 0);

    // Swap at frame boundary; accept+retire together keeps outstanding at 0.
    out_usedw = 9'd19; auto_ret = 1; s = n_acc;
    enable = 1;
    wait_acc(s + 3, 50, "swap_prefix");
    swap_req = 1; tick();
    tick();
    swap_req = 1; tick();
    wait_acc(s + 20, 200, "swap_stream");
    chk("swap_w0", acc_q[s], 25'h1000);
    chk("swap_w7", acc_q[s + 7], 25'h1007);
    chk("swap_new_w0", acc_q[s + 8], 25'h2000);
    chk("swap_no_double", acc_q[s + 16], 25'h2000);
    chk("swap_ack_count", n_ack, 1);
    chk("swap_active_base", active_base, 25'h2000);

    // Retire with nothing in flight sets a sticky error.
    enable = 0;
    repeat (4) tick();
    auto_ret = 0;
    repeat (4) tick();
    chk("pre_err", retire_err, 0);
    rsp_retire = 1; tick();
    tick();
    chk("retire_err_set", retire_err, 1);
    repeat (5) tick();
    chk("retire_err_sticky", retire_err, 1);

    // Asynchronous reset with a command pending, then address wrap.
    out_usedw = 0; auto_ret = 1; cmd_ready = 1; enable = 1;
    wait_acc(n_acc + 2, 60, "pre_reset_stream");
    cmd_ready = 0;
    wait_valid(10, "pre_reset_pending");
    #2 portV_arst = 1;
    #1;
    chk("arst_clears_valid", cmd_valid, 0);
    chk("arst_clears_err", retire_err, 0);
    buf0_base = 25'h1FFFFFF;
    repeat (2) tick();
    portV_arst = 0;
    cmd_ready = 1; s = n_acc; fs0 = n_fs;
    wait_acc(s + 9, 100, "wrap_stream");
    chk("wrap_a0", acc_q[s], 25'h1FFFFFF);
    chk("wrap_a1", acc_q[s + 1], 25'h0000000);
    chk("wrap_a2", acc_q[s + 2], 25'h0000001);
    chk("wrap_a3", acc_q[s + 3], 25'h0000002);
    chk("wrap_next_frame", acc_q[s + 8], 25'h1FFFFFF);
    chk("wrap_frame_starts", n_fs - fs0, 2);

`ifdef VGA_PREFETCH_STATS_EN
    auto_ret = 0; enable = 0; cmd_ready = 0; out_usedw = 9'd1;
    tick();
    portV_arst = 1;
    repeat (2) tick();
    portV_arst = 0;
    enable = 1;
    repeat (4) tick();
    chk("stats_underrun_zero", underrun_count, 0);
    out_usedw = 0;
    repeat (5) tick();
    out_usedw = 9'd1;
    tick();
    chk("stats_underrun_5", underrun_count, 5);
    chk("stats_peak_zero", peak_outstanding, 0);
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
